// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing and command codes.
// Used by ps2_host_tx and ps2_line_sync; the receive path may import it as well.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQUEST = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5,
        ST_ACK     = 3'd6,
        ST_RELEASE = 3'd7
    } ps2_tx_state_e;

    // Defaults assume a 50 MHz system clock.
    localparam int INHIBIT_CYCLES = 6000;
    localparam int START_TIMEOUT  = 750000;
    localparam int XFER_TIMEOUT   = 100000;

    localparam logic [7:0] CMD_RESET        = 8'hFF;
    localparam logic [7:0] CMD_ENABLE       = 8'hF4;
    localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS2_CLK and PS2_DAT pins plus a registered
// falling-edge pulse on the synchronised clock; shared with the receive path.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic clk_fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       fall_q;

    // Lines idle high, so reset the chain to 1 to avoid a false edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
            fall_q     <= clk_prev_q & ~clk_sync_q[1];
        end
    end

    assign clk_sync_o = clk_sync_q[1];
    assign dat_sync_o = dat_sync_q[1];
    assign clk_fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11 device-clocked
// bits, acknowledge check. Define PS2_TX_TIMEOUT_EN to build the start/transfer timeouts.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] command_byte,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_sent,
    output logic       error_ack,
    output logic       error_timeout
);
    import ps2_pkg::*;

    if (INHIBIT_CYCLES < 1 || START_TIMEOUT < 1 || XFER_TIMEOUT < 1) begin : g_bad_cfg
        $error("ps2_host_tx: timing parameters must be at least 1");
    end

    localparam logic [31:0] INHIBIT_LAST = 32'(INHIBIT_CYCLES - 1);

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .clk_sync_o (clk_sync),
        .dat_sync_o (dat_sync),
        .clk_fall_o (clk_fall)
    );

    ps2_tx_state_e state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   inh_cnt_q, inh_cnt_d;
    logic          dat_oe_q, dat_oe_d;
    logic          lines_high_q;
    logic          command_sent_q, command_sent_d;
    logic          error_ack_q, error_ack_d;
    logic          error_timeout_q, error_timeout_d;
    logic          tmo_expired;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [31:0] START_LAST = 32'(START_TIMEOUT - 1);
    localparam logic [31:0] XFER_LAST  = 32'(XFER_TIMEOUT - 1);

    logic [31:0] tmo_q, tmo_d;

    // One counter serves both windows: it restarts on the first device fall.
    always_comb begin
        tmo_d       = 32'd0;
        tmo_expired = 1'b0;
        case (state_q)
            ST_REQUEST: begin
                tmo_expired = (tmo_q == START_LAST);
                tmo_d       = clk_fall ? 32'd0 : tmo_q + 32'd1;
            end
            ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_RELEASE: begin
                tmo_expired = (tmo_q == XFER_LAST);
                tmo_d       = tmo_q + 32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) tmo_q <= 32'd0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        byte_d          = byte_q;
        parity_d        = parity_q;
        bit_cnt_d       = bit_cnt_q;
        inh_cnt_d       = 32'd0;
        dat_oe_d        = dat_oe_q;
        command_sent_d  = 1'b0;
        error_ack_d     = 1'b0;
        error_timeout_d = 1'b0;

        // A timeout wins over a fall arriving in the same cycle.
        if (tmo_expired) begin
            state_d         = ST_IDLE;
            dat_oe_d        = 1'b0;
            bit_cnt_d       = 4'd0;
            error_timeout_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 4'd0;
                    dat_oe_d  = 1'b0;
                    if (send_command) begin
                        byte_d   = command_byte;
                        parity_d = odd_parity(command_byte);
                        state_d  = ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_q == INHIBIT_LAST) begin
                        state_d  = ST_REQUEST;
                        dat_oe_d = 1'b1;
                    end else begin
                        inh_cnt_d = inh_cnt_q + 32'd1;
                    end
                end
                ST_REQUEST: begin
                    if (clk_fall) begin
                        dat_oe_d  = ~byte_q[0];
                        bit_cnt_d = 4'd1;
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (clk_fall) begin
                        dat_oe_d  = ~byte_q[bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (clk_fall) begin
                        dat_oe_d  = ~parity_q;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (clk_fall) begin
                        dat_oe_d  = 1'b0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (clk_fall) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (!dat_sync) begin
                            state_d = ST_RELEASE;
                        end else begin
                            error_ack_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (lines_high_q) begin
                        command_sent_d = 1'b1;
                        bit_cnt_d      = 4'd0;
                        state_d        = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            byte_q          <= 8'd0;
            parity_q        <= 1'b0;
            bit_cnt_q       <= 4'd0;
            inh_cnt_q       <= 32'd0;
            dat_oe_q        <= 1'b0;
            lines_high_q    <= 1'b0;
            command_sent_q  <= 1'b0;
            error_ack_q     <= 1'b0;
            error_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_q          <= byte_d;
            parity_q        <= parity_d;
            bit_cnt_q       <= bit_cnt_d;
            inh_cnt_q       <= inh_cnt_d;
            dat_oe_q        <= dat_oe_d;
            lines_high_q    <= clk_sync & dat_sync;
            command_sent_q  <= command_sent_d;
            error_ack_q     <= error_ack_d;
            error_timeout_q <= error_timeout_d;
        end
    end

    assign ps2_clk_oe    = (state_q == ST_INHIBIT);
    assign ps2_dat_oe    = dat_oe_q;
    assign busy          = (state_q != ST_IDLE);
    assign command_sent  = command_sent_q;
    assign error_ack     = error_ack_q;
    assign error_timeout = error_timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a wired-AND PS/2 device model on scaled-down timing.
// Expected frames are queued when a command is sent and compared when the device finishes clocking.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int ST   = 300;
    localparam int XT   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] command_byte = 8'h00;
    logic       send_command = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy;
    logic       command_sent, error_ack, error_timeout;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .XFER_TIMEOUT   (XT)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .command_byte  (command_byte),
        .send_command  (send_command),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_dat_in    (ps2_dat_in),
        .ps2_clk_oe    (ps2_clk_oe),
        .ps2_dat_oe    (ps2_dat_oe),
        .busy          (busy),
        .command_sent  (command_sent),
        .error_ack     (error_ack),
        .error_timeout (error_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];
    int cs_cnt = 0;
    int ea_cnt = 0;
    int et_cnt = 0;

    always @(posedge clk) begin
        if (command_sent)  cs_cnt++;
        if (error_ack)     ea_cnt++;
        if (error_timeout) et_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
        check({tag, "_dat_oe"}, 32'(ps2_dat_oe), 32'd0);
        check({tag, "_busy"},   32'(busy),       32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        command_byte = b;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
        check("accept_busy",   32'(busy),       32'd1);
        check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
        exp_q.push_back({1'b1, ~^b, b, 1'b0});
    endtask

    // Called in the first busy cycle; returns in the first REQUEST cycle.
    task automatic wait_request();
        int n = 0;
        while (ps2_clk_oe && n < INH + 50) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_len", 32'(n), 32'(INH));
        check("request_dat_oe", 32'(ps2_dat_oe), 32'd1);
    endtask

    task automatic device_frame(input bit ack_low, input bit poke_busy, input bit abort_mid);
        logic [10:0] got;
        int base_cs, base_ea, base_et, n;
        got = '0;
        repeat (5) @(negedge clk);
        got[0] = ps2_dat_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (poke_busy && k == 3) begin
                command_byte = 8'h55;
                send_command = 1'b1;
                @(negedge clk);
                send_command = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            got[k] = ps2_dat_in;
            if (abort_mid && k == 4) begin
                reset = 1'b1;
                @(negedge clk);
                check_quiet("mid_reset");
                reset = 1'b0;
                dev_clk = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                repeat (5) @(negedge clk);
                return;
            end
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (exp_q.size() == 0) check("frame_queue_empty", 32'd1, 32'd0);
        else                   check("frame", 32'(got), 32'(exp_q.pop_front()));

        base_cs = cs_cnt;
        base_ea = ea_cnt;
        base_et = et_cnt;
        repeat (HALF / 2) @(negedge clk);
        dev_dat = ack_low ? 1'b0 : 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (ack_low) begin
            repeat (4) @(negedge clk);
            dev_dat = 1'b1;
            // Pins are first sampled on the next edge; the pulse follows three edges later.
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!command_sent && n < 20);
            check("sent_latency", 32'(n), 32'd4);
            check("sent_busy", 32'(busy), 32'd0);
        end
        repeat (10) @(negedge clk);
        check("sent_count",    32'(cs_cnt - base_cs), ack_low ? 32'd1 : 32'd0);
        check("ack_err_count", 32'(ea_cnt - base_ea), ack_low ? 32'd0 : 32'd1);
        check("tmo_count",     32'(et_cnt - base_et), 32'd0);
        check_quiet("frame_end");
        dev_dat = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_et, n;
        do_reset();
        check_quiet("reset");
        check("reset_sent", 32'(command_sent),  32'd0);
        check("reset_eack", 32'(error_ack),     32'd0);
        check("reset_etmo", 32'(error_timeout), 32'd0);

        send_cmd(CMD_ENABLE);
        wait_request();
        device_frame(1'b1, 1'b0, 1'b0);

        send_cmd(8'h00);
        wait_request();
        device_frame(1'b1, 1'b0, 1'b0);

        send_cmd(CMD_RESET);
        wait_request();
        device_frame(1'b1, 1'b0, 1'b0);

        // Device never clocks.
        base_et = et_cnt;
        send_cmd(8'hA7);
        wait_request();
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!error_timeout && n < ST + 50) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout_len", 32'(n), 32'(ST));
        check_quiet("start_timeout");
        repeat (5) @(negedge clk);
        check("start_timeout_count", 32'(et_cnt - base_et), 32'd1);
`else
        repeat (2 * ST) @(negedge clk);
        check("no_timeout_count", 32'(et_cnt - base_et), 32'd0);
        check("no_timeout_busy",  32'(busy), 32'd1);
        do_reset();
        check_quiet("no_timeout_reset");
`endif
        void'(exp_q.pop_front());

        send_cmd(8'hA5);
        wait_request();
        device_frame(1'b0, 1'b0, 1'b0);

        send_cmd(8'h3C);
        wait_request();
        device_frame(1'b1, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check("busy_send_not_queued", 32'(busy), 32'd0);

        send_cmd(8'h81);
        wait_request();
        device_frame(1'b1, 1'b0, 1'b1);

        send_cmd(CMD_SET_DEFAULTS);
        wait_request();
        device_frame(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            send_cmd(8'($urandom_range(0, 255)));
            wait_request();
            device_frame(1'b1, 1'b0, 1'b0);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends one command byte to the attached mouse or keyboard, for example 0xF4 (enable data reporting) or 0xFF (reset). It sits beside the existing PS/2 receive path on the shared PS2_CLK/PS2_DAT pins and drives them through open-drain enables. The block handles the host request-to-send sequence, serialises start, data, parity and stop bits on device-generated clock edges, and checks the device acknowledge.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000, number of CLOCK_50 cycles the PS/2 clock is held low before the request (120 µs at 50 MHz)
- START_TIMEOUT, 750000, maximum cycles from request until the first device falling edge (15 ms)
- XFER_TIMEOUT, 100000, maximum cycles from the first falling edge until the acknowledge completes (2 ms)

Ports:
- CLOCK_50  in  1  system clock; the only clock in the block
- reset  in  1  synchronous, active-high reset
- command_byte  in  8  byte to transmit; sampled when the command is accepted
- send_command  in  1  one-cycle request; honoured only while busy=0
- ps2_clk_in  in  1  raw PS2_CLK pin value; asynchronous
- ps2_dat_in  in  1  raw PS2_DAT pin value; asynchronous
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release
- busy  out  1  transfer in progress
- command_sent  out  1  one-cycle pulse: device acknowledged the byte
- error_ack  out  1  one-cycle pulse: acknowledge bit was high
- error_timeout  out  1  one-cycle pulse: start or transfer timeout expired

## Operation
- Both pin inputs pass through a 2-flop synchroniser. A falling edge (fall) is detected when the previous synchronised clock is 1 and the current one is 0.
- States:
  - IDLE: on send_command, latch the byte and parity = ~^byte, then go to INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then go to REQUEST.
  - REQUEST: clk_oe=0 and dat_oe=1 (start bit 0). Wait for fall.
  - DATA: on each fall, set dat_oe = ~bit[n] for n = 0..7, LSB first.
  - PARITY: on fall, set dat_oe = ~parity.
  - STOP: on fall, set dat_oe=0 (released).
  - ACK: on fall, sample synchronised DAT. If DAT=0, go to RELEASE. If DAT=1, pulse error_ack and go to IDLE.
  - RELEASE: wait until CLK=1 and DAT=1 synchronised, pulse command_sent, go to IDLE.
- A 4-bit bit counter tracks the 11 falls per transfer (start, 8 data, parity, stop).
- busy=1 in every state except IDLE. send_command while busy=1 is ignored and not queued.
- On any error, both enables release in the same cycle as the error pulse.
- Reset at any point returns to IDLE on the next edge. After reset: both enables 0, busy 0, all pulses 0, counters 0.
- The receive path must ignore traffic while busy=1. That gating is the integrator's responsibility.

## Timing
- send_command accepted in cycle 0 → busy=1 and clk_oe=1 in cycle 1.
- clk_oe falls and dat_oe rises in the same cycle, INHIBIT_CYCLES cycles after entering INHIBIT.
- Pin falling edge → dat_oe update 3 cycles later (2 sync stages + 1 edge register). This is far inside the device's ≥30 µs clock-low phase.
- command_sent asserts 3 cycles after both pins read high. busy drops in the same cycle as command_sent.
- Pulses are exactly one cycle wide. At most one of command_sent, error_ack and error_timeout fires per transfer.
- A timeout counter expiring in the same cycle as a fall takes priority: the transfer is an error.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - START_TIMEOUT counts in REQUEST.
  - XFER_TIMEOUT counts from the first fall through RELEASE.
  - Expiry pulses error_timeout, releases both lines and returns to IDLE.
- PS2_TX_TIMEOUT_EN undefined:
  - No timeout counters are built.
  - error_timeout is tied to 0.
  - The FSM waits indefinitely for device edges.

## Structure
- Package ps2_pkg holds:
  - the state enum
  - default timing constants (INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT)
  - common command codes: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_DEFAULTS=8'hF6
- Sub-module ps2_line_sync holds the 2-flop synchronisers for both pins plus CLK falling-edge detection. It is reusable by the receive path.

## Test plan
- Send 0xF4 with a device model clocking at 12.5 kHz:
  - dat_oe bits (inverted) read as start 0, data 0,0,1,0,1,1,1,1, parity 0, stop released.
  - Model acks with DAT low → one command_sent pulse, busy low.
- Send 0x00 → parity bit 1. Send 0xFF → parity bit 1. Check both complete with command_sent.
- Model never clocks (macro defined) → error_timeout exactly START_TIMEOUT cycles after REQUEST is entered; both enables 0.
- Model leaves DAT high at the ack edge → error_ack pulse; command_sent never asserts.
- Assert send_command while busy with byte 0x55 → ignored; the frame in flight is unchanged.
- Assert reset mid-DATA (after bit 3) → next cycle both enables 0 and busy 0. A new send_command 0xF6 then completes normally.
